reg_bank: RTL and testbench

//   32 x 32-bit general-purpose register file for the multicycle MIPS datapath.

---
 rtl/reg_bank.sv | 69 ++++++
 tb/tb_reg_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: 32-entry general-purpose register file for the multicycle MIPS datapath.
// Two combinational read ports (rs/rt) and one clocked write port.
// Register 0 always reads as zero. Register 29 ($sp) resets to SP_INIT.
// With BYPASS=1, a read of the register being written this cycle returns write_data.
module reg_bank #(
   parameter int          DATA_W  = 32,
   parameter int unsigned SP_INIT = 227,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write,
   input  logic [4:0]        read_reg1,
   input  logic [4:0]        read_reg2,
   input  logic [4:0]        write_reg,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   localparam logic [4:0]        SP_IDX   = 5'd29;
   localparam logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_INIT);

   logic [DATA_W-1:0] regs [32];

   // A write is live only outside reset, and writes to $zero are dropped here.
   // Bypass and storage both use this signal, so they always agree.
   logic write_live;
   assign write_live = reg_write && !reset && (write_reg != 5'd0);

   // Storage: asynchronous reset of every entry, then one write per rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: every entry has a reset value, so no read can return X after
         // reset. This makes the storage flops, not a RAM macro, and that is
         // what we want: $sp needs a non-zero reset value.
         for (int i = 0; i < 32; i++) begin
            regs[i] <= (5'(i) == SP_IDX) ? SP_RESET : '0;
         end
      end else if (write_live) begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples the values from before the edge.
         regs[write_reg] <= write_data;
      end
   end

   // Read port 1: index 0 is hardwired to zero, with optional same-cycle bypass.
   always_comb begin
      // NOTE: the default assignment comes first, so every path drives the
      // output and no latch is inferred.
      read_data1 = regs[read_reg1];
      if (read_reg1 == 5'd0) begin
         read_data1 = '0;
      end else if (BYPASS && write_live && (write_reg == read_reg1)) begin
         read_data1 = write_data;
      end
   end

   // Read port 2: same behaviour as port 1.
   always_comb begin
      read_data2 = regs[read_reg2];
      if (read_reg2 == 5'd0) begin
         read_data2 = '0;
      end else if (BYPASS && write_live && (write_reg == read_reg2)) begin
         read_data2 = write_data;
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: scoreboard bench for reg_bank.
// Two instances share all inputs: one with BYPASS=1 and one with BYPASS=0.
// The stimulus process pushes the expected read values into a queue.
// A separate monitor process pops each entry and compares it with both instances.
module tb_reg_bank;

   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic          reg_write;
   logic [4:0]    read_reg1;
   logic [4:0]    read_reg2;
   logic [4:0]    write_reg;
   logic [DW-1:0] write_data;
   logic [DW-1:0] rd1_byp;
   logic [DW-1:0] rd2_byp;
   logic [DW-1:0] rd1_nb;
   logic [DW-1:0] rd2_nb;

   reg_bank #(.DATA_W(DW), .SP_INIT(227), .BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .reg_write(reg_write),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .write_reg(write_reg), .write_data(write_data),
      .read_data1(rd1_byp), .read_data2(rd2_byp)
   );

   reg_bank #(.DATA_W(DW), .SP_INIT(227), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .reg_write(reg_write),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .write_reg(write_reg), .write_data(write_data),
      .read_data1(rd1_nb), .read_data2(rd2_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [DW-1:0] e1;    // expected read_data1, BYPASS=1
      logic [DW-1:0] e2;    // expected read_data2, BYPASS=1
      logic [DW-1:0] n1;    // expected read_data1, BYPASS=0
      logic [DW-1:0] n2;    // expected read_data2, BYPASS=0
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: consume each scoreboard entry and compare it with both instances.
   initial begin
      exp_t it;
      forever begin
         wait (sb.size() != 0);
         it = sb[0];
         check({it.name, ".rd1"},    rd1_byp, it.e1);
         check({it.name, ".rd2"},    rd2_byp, it.e2);
         check({it.name, ".nb.rd1"}, rd1_nb,  it.n1);
         check({it.name, ".nb.rd2"}, rd2_nb,  it.n2);
         void'(sb.pop_front());
      end
   end

   // Set both read indices, let the reads settle, post the expected values
   // (separate values for BYPASS=0), then wait a bounded time for the monitor.
   task automatic probe4(input string name, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input logic [DW-1:0] n1, input logic [DW-1:0] n2);
      exp_t it;
      read_reg1 = r1;
      read_reg2 = r2;
      #1;
      it.name = name;
      it.e1 = e1;
      it.e2 = e2;
      it.n1 = n1;
      it.n2 = n2;
      sb.push_back(it);
      fork
         wait (sb.size() == 0);
         #2;
      join_any
      disable fork;
      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s.timeout: queue depth %0d, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Probe where both bypass settings expect the same values.
   task automatic probe(input string name, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      probe4(name, r1, r2, e1, e2, e1, e2);
   endtask

   // Perform one write across a single rising edge.
   task automatic do_write(input logic [4:0] idx, input logic [DW-1:0] data);
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = idx;
      write_data = data;
      @(posedge clk);
      #1;
      reg_write = 1'b0;
   endtask

   // Stimulus: directed vectors with hand-computed expected values.
   initial begin
      reset      = 1'b1;
      reg_write  = 1'b0;
      read_reg1  = '0;
      read_reg2  = '0;
      write_reg  = '0;
      write_data = '0;

      // 1. Reset values are visible without any clock edge.
      #1;
      probe("rst_29_5", 5'd29, 5'd5, 32'd227, 32'd0);
      reset = 1'b0;
      probe("rst_0_0", 5'd0, 5'd0, 32'd0, 32'd0);

      // 2. Basic write with a latency of one edge.
      do_write(5'd8, 32'hDEADBEEF);
      probe("wr8", 5'd8, 5'd9, 32'hDEADBEEF, 32'd0);

      // 3. A write to $zero is discarded, and $zero is never bypassed.
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = 5'd0;
      write_data = 32'hFFFFFFFF;
      probe("wr0_pre", 5'd0, 5'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      reg_write = 1'b0;
      probe("wr0_post", 5'd0, 5'd8, 32'd0, 32'hDEADBEEF);

      // 4. Same-cycle bypass on both ports versus no bypass.
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = 5'd17;
      write_data = 32'd5;
      probe4("byp_both", 5'd17, 5'd17, 32'd5, 32'd5, 32'd0, 32'd0);
      probe4("byp_one", 5'd8, 5'd17, 32'hDEADBEEF, 32'd5, 32'hDEADBEEF, 32'd0);
      @(posedge clk);
      #1;
      reg_write = 1'b0;
      probe("byp_after", 5'd17, 5'd17, 32'd5, 32'd5);

      // 5. Async reset pulse between edges restores $sp and clears $ra.
      do_write(5'd29, 32'd100);
      do_write(5'd31, 32'h0040);
      probe("sp_ra_wr", 5'd29, 5'd31, 32'd100, 32'h0040);
      @(negedge clk);
      #1;
      reset = 1'b1;
      probe("rst_pulse_on", 5'd29, 5'd31, 32'd227, 32'd0);
      reset = 1'b0;
      probe("rst_pulse_off", 5'd29, 5'd31, 32'd227, 32'd0);
      @(posedge clk);
      #1;
      probe("rst_edge_idle", 5'd29, 5'd8, 32'd227, 32'd0);

      // Writes are blocked while reset is held, and no bypass happens then.
      @(negedge clk);
      reset      = 1'b1;
      reg_write  = 1'b1;
      write_reg  = 5'd29;
      write_data = 32'd55;
      probe("rst_hold_byp", 5'd29, 5'd29, 32'd227, 32'd227);
      @(posedge clk);
      #1;
      reg_write = 1'b0;
      reset     = 1'b0;
      probe("rst_hold_wr", 5'd29, 5'd29, 32'd227, 32'd227);

      // 6. Fill indices 1..31 with i*3. Idle edges must not disturb the contents.
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i * 3));
      end
      @(negedge clk);
      reg_write  = 1'b0;
      write_reg  = 5'd5;
      write_data = 32'hFFFFFFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 1; i < 32; i++) begin
         probe($sformatf("fill_%0d", i), 5'(i), 5'(32 - i), 32'(i * 3), 32'((32 - i) * 3));
      end
      probe("fill_zero", 5'd0, 5'd31, 32'd0, 32'd93);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Watchdog: the run must end on its own.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
